jump_unit: RTL and testbench
============================

Name: jump_unit

Overview:
- Control-flow stage directly upstream of the program counter; produces its absolute-jump enable and target each cycle.
- Consumes decoded control-flow flags plus the current program counter.
- Resolves unconditional jumps, conditional branches (via a jump-target lookup table), calls and returns (via a hardware return-address stack).
- Holds the PC frozen on halt or on a stack fault.

Parameters:
- D, 12, program counter / target width.
- L, 5, LUT index width; LUT has 2**L entries of D bits.
- S, 4, return-stack depth in entries; must be ≥2.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous reset, active-high.
- prog_ctr  input  D  current program counter.
- jump  input  1  unconditional jump via LUT.
- branch  input  1  conditional jump via LUT, taken when cond_flag=1.
- cond_flag  input  1  branch condition from ALU flag register.
- call  input  1  push prog_ctr+1, jump via LUT.
- ret  input  1  pop return address, jump to it.
- lut_idx  input  L  LUT entry selector.
- halt_req  input  1  stop execution.
- absjump_en  output  1  jump enable to PC.
- target  output  D  jump target to PC.
- depth  output  $clog2(S+1)  current stack occupancy.
- done  output  1  high in HALT.
- fault  output  1  high in FAULT.

Behaviour:
- FSM states RUN, HALT, FAULT. Reset → RUN, stack pointer 0, depth=0, done=0, fault=0. While reset is high, absjump_en=0 and target=0.
- absjump_en and target are combinational from the current inputs and state. The PC samples them at the next edge (zero added latency).
- Stack and FSM update on posedge clk.
- RUN decode priority when several flags are high: halt_req > ret > call > jump > branch.
  - halt_req: absjump_en=1, target=prog_ctr; next state HALT.
  - ret, depth>0: target=top of stack, absjump_en=1; pop.
  - ret, depth=0: absjump_en=1, target=prog_ctr; next state FAULT; no pop.
  - call, depth<S: target=lut[lut_idx], absjump_en=1; push (prog_ctr+1) mod 2**D; wraps at all-ones.
  - call, depth=S: absjump_en=1, target=prog_ctr; next state FAULT; no push.
  - jump: target=lut[lut_idx], absjump_en=1.
  - branch & cond_flag: as jump.
  - branch & !cond_flag: absjump_en=0 (PC increments).
  - No flag set: absjump_en=0; target=lut[lut_idx] (don't-care, but defined).
- HALT and FAULT: absjump_en=1, target=prog_ctr every cycle (PC frozen). All control inputs ignored, stack unchanged. Exit only via reset.
- done=1 iff state==HALT. fault=1 iff state==FAULT. Both are registered state decodes.
- Reset mid-operation: stack contents need not clear; the pointer clears, so no stale entry is reachable.

Optional Feature:
- Macro JUMP_LUT_WRITE_EN.
- Defined:
  - Adds inputs lut_we (1), lut_waddr (L), lut_wdata (D).
  - LUT is a register array initialised on reset from the package defaults; written at posedge when lut_we=1.
  - Write and read to the same index in the same cycle: the read returns the old value; the new value is visible next cycle.
  - Writes are accepted in all states.
- Undefined: LUT is the constant default table from the package; no write ports.

Decomposition:
- Package jump_pkg:
  - state enum {RUN, HALT, FAULT}.
  - JUMP_LUT_DEFAULT constant array (entry i = 16*i default).
  - Decode priority encoding typedef.
- Sub-module ret_stack: S×D register stack.
  - push/pop/top/depth/full/empty outputs.
  - Synchronous reset of the pointer.
  - Caller guarantees no push-when-full or pop-when-empty.

Test Plan:
- Reset, then no flags for 3 cycles → absjump_en=0, depth=0, done=0, fault=0.
- prog_ctr=0x010, jump, lut_idx=3 → absjump_en=1, target=0x030.
- branch, lut_idx=2, cond_flag=0 → absjump_en=0; same with cond_flag=1 → target=0x020.
- call at prog_ctr=0x005, lut_idx=1 → target=0x010, depth=1; next ret → target=0x006, depth=0.
- S=4: five calls → fifth cycle target=prog_ctr, then fault=1, depth=4, PC held. Separately, ret at depth 0 → fault=1.
- halt_req together with call at prog_ctr=0x040 → target=0x040, next cycle done=1, depth unchanged; then reset → done=0.
- JUMP_LUT_WRITE_EN: write lut[3]=0x123 while jump lut_idx=3 → target=0x030 that cycle, 0x123 next cycle.

Source files
------------

// File: rtl/jump_pkg.sv
// Shared types and defaults for the jump unit.
package jump_pkg;

  typedef enum logic [1:0] {
    RUN,
    HALT,
    FAULT
  } state_t;

  // Decoded control-flow request for the current cycle, after priority resolution.
  typedef enum logic [2:0] {
    DEC_NONE,
    DEC_HALT,
    DEC_RET,
    DEC_CALL,
    DEC_JUMP,
    DEC_BRANCH_TAKEN,
    DEC_BRANCH_NOT
  } dec_t;

  localparam int unsigned JUMP_LUT_STRIDE = 16;

  // Default jump-target table: entry i holds 16*i (caller truncates to D bits).
  function automatic logic [31:0] jump_lut_default(input logic [31:0] idx);
    return idx * JUMP_LUT_STRIDE;
  endfunction

endpackage

// File: rtl/jump_unit_ret_stack.sv
// Return-address stack: S entries of D bits, pointer cleared on reset.
// Caller must not push when full or pop when empty.
module ret_stack #(
  parameter int unsigned D = 12,
  parameter int unsigned S = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [D-1:0]             push_data,
  output logic [D-1:0]             top,
  output logic [$clog2(S+1)-1:0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(S+1);
  localparam int unsigned IW = $clog2(S);

  logic [D-1:0]  r_mem [S];
  logic [PW-1:0] r_ptr;
  logic [IW-1:0] w_top_idx;
  logic [IW-1:0] w_wr_idx;

  assign w_top_idx = IW'(r_ptr - PW'(1));
  assign w_wr_idx  = IW'(r_ptr);
  assign full      = (r_ptr == PW'(S));
  assign empty     = (r_ptr == '0);
  assign depth     = r_ptr;
  assign top       = empty ? '0 : r_mem[w_top_idx];

  // Stack pointer: cleared on reset, moves on accepted push/pop
  always_ff @(posedge clk) begin
    if (reset)
      r_ptr <= '0;
    else if (push && !full)
      r_ptr <= r_ptr + PW'(1);
    else if (pop && !empty)
      r_ptr <= r_ptr - PW'(1);
  end

  // Entry storage: no reset, stale entries are unreachable once the pointer clears
  always_ff @(posedge clk) begin
    if (!reset && push && !full)
      r_mem[w_wr_idx] <= push_data;
  end

endmodule

// File: rtl/jump_unit.sv
// Jump unit: resolves jumps, branches, calls and returns into an absolute
// jump enable/target for the program counter; freezes the PC on halt/fault.
// Optional macro JUMP_LUT_WRITE_EN makes the target LUT writable.
module jump_unit
  import jump_pkg::*;
#(
  parameter int unsigned D = 12,
  parameter int unsigned L = 5,
  parameter int unsigned S = 4
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef JUMP_LUT_WRITE_EN
  input  logic                   lut_we,
  input  logic [L-1:0]           lut_waddr,
  input  logic [D-1:0]           lut_wdata,
`endif
  input  logic [D-1:0]           prog_ctr,
  input  logic                   jump,
  input  logic                   branch,
  input  logic                   cond_flag,
  input  logic                   call,
  input  logic                   ret,
  input  logic [L-1:0]           lut_idx,
  input  logic                   halt_req,
  output logic                   absjump_en,
  output logic [D-1:0]           target,
  output logic [$clog2(S+1)-1:0] depth,
  output logic                   done,
  output logic                   fault
);

  state_t       r_state;
  state_t       w_next_state;
  dec_t         w_dec;
  logic [D-1:0] w_lut_rd;
  logic [D-1:0] w_stack_top;
  logic [D-1:0] w_push_data;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;

`ifdef JUMP_LUT_WRITE_EN
  logic [D-1:0] r_lut [2**L];

  // Writable LUT: defaults reloaded on reset, writes accepted in every state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2**L; i++)
        r_lut[i] <= D'(jump_lut_default(i));
    end else if (lut_we) begin
      r_lut[lut_waddr] <= lut_wdata;
    end
  end

  assign w_lut_rd = r_lut[lut_idx];
`else
  assign w_lut_rd = D'(jump_lut_default(32'(lut_idx)));
`endif

  assign w_push_data = prog_ctr + D'(1);

  ret_stack #(
    .D(D),
    .S(S)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_push_data),
    .top       (w_stack_top),
    .depth     (depth),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Priority decode of control-flow flags: halt > ret > call > jump > branch
  always_comb begin
    w_dec = DEC_NONE;
    if (halt_req)    w_dec = DEC_HALT;
    else if (ret)    w_dec = DEC_RET;
    else if (call)   w_dec = DEC_CALL;
    else if (jump)   w_dec = DEC_JUMP;
    else if (branch) w_dec = cond_flag ? DEC_BRANCH_TAKEN : DEC_BRANCH_NOT;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_next_state;
  end

  // Next state, stack control and PC jump outputs
  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    absjump_en   = 1'b0;
    target       = w_lut_rd;
    if (reset) begin
      target = '0;
    end else begin
      unique case (r_state)
        RUN: begin
          unique case (w_dec)
            DEC_HALT: begin
              absjump_en   = 1'b1;
              target       = prog_ctr;
              w_next_state = HALT;
            end
            DEC_RET: begin
              absjump_en = 1'b1;
              if (w_empty) begin
                target       = prog_ctr;
                w_next_state = FAULT;
              end else begin
                target = w_stack_top;
                w_pop  = 1'b1;
              end
            end
            DEC_CALL: begin
              absjump_en = 1'b1;
              if (w_full) begin
                target       = prog_ctr;
                w_next_state = FAULT;
              end else begin
                w_push = 1'b1;
              end
            end
            DEC_JUMP, DEC_BRANCH_TAKEN: absjump_en = 1'b1;
            default: absjump_en = 1'b0;
          endcase
        end
        default: begin
          absjump_en = 1'b1;
          target     = prog_ctr;
        end
      endcase
    end
  end

  assign done  = (r_state == HALT);
  assign fault = (r_state == FAULT);

endmodule

// File: tb/tb_jump_unit.sv
// Directed self-checking bench for jump_unit (D=12, L=5, S=4).
// Exercises the JUMP_LUT_WRITE_EN path when that macro is defined.
module tb_jump_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] prog_ctr;
  logic        jump, branch, cond_flag, call, ret, halt_req;
  logic [4:0]  lut_idx;
  logic        absjump_en;
  logic [11:0] target;
  logic [2:0]  depth;
  logic        done, fault;
`ifdef JUMP_LUT_WRITE_EN
  logic        lut_we;
  logic [4:0]  lut_waddr;
  logic [11:0] lut_wdata;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  jump_unit #(.D(12), .L(5), .S(4)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef JUMP_LUT_WRITE_EN
    .lut_we     (lut_we),
    .lut_waddr  (lut_waddr),
    .lut_wdata  (lut_wdata),
`endif
    .prog_ctr   (prog_ctr),
    .jump       (jump),
    .branch     (branch),
    .cond_flag  (cond_flag),
    .call       (call),
    .ret        (ret),
    .lut_idx    (lut_idx),
    .halt_req   (halt_req),
    .absjump_en (absjump_en),
    .target     (target),
    .depth      (depth),
    .done       (done),
    .fault      (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    jump = 0; branch = 0; cond_flag = 0; call = 0; ret = 0; halt_req = 0;
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;
  endtask

  initial begin
    clr();
    reset    = 1;
    prog_ctr = 12'h123;
    lut_idx  = 5'd3;
`ifdef JUMP_LUT_WRITE_EN
    lut_we = 0; lut_waddr = '0; lut_wdata = '0;
`endif
    tick();
    chk("rst_en", 32'(absjump_en), 0);
    chk("rst_target", 32'(target), 0);
    jump = 1;
    #1;
    chk("rst_en_jump", 32'(absjump_en), 0);
    tick();
    clr();
    reset = 0;
    #1;

    // Idle cycles
    for (int i = 0; i < 3; i++) begin
      chk("idle_en", 32'(absjump_en), 0);
      chk("idle_target", 32'(target), 32'h030);
      chk("idle_depth", 32'(depth), 0);
      chk("idle_done", 32'(done), 0);
      chk("idle_fault", 32'(fault), 0);
      tick();
    end

    // Unconditional jump
    prog_ctr = 12'h010; jump = 1; lut_idx = 5'd3;
    #1;
    chk("jump_en", 32'(absjump_en), 1);
    chk("jump_target", 32'(target), 32'h030);
    tick(); clr();

    // Branch not taken / taken
    branch = 1; lut_idx = 5'd2; cond_flag = 0;
    #1;
    chk("br_nt_en", 32'(absjump_en), 0);
    cond_flag = 1;
    #1;
    chk("br_t_en", 32'(absjump_en), 1);
    chk("br_t_target", 32'(target), 32'h020);
    tick(); clr();

    // Call then return
    prog_ctr = 12'h005; call = 1; lut_idx = 5'd1;
    #1;
    chk("call_target", 32'(target), 32'h010);
    chk("call_en", 32'(absjump_en), 1);
    tick(); clr();
    chk("call_depth", 32'(depth), 1);
    ret = 1;
    #1;
    chk("ret_target", 32'(target), 32'h006);
    chk("ret_en", 32'(absjump_en), 1);
    tick(); clr();
    chk("ret_depth", 32'(depth), 0);

    // Return address wraps at all-ones PC
    prog_ctr = 12'hFFF; call = 1; lut_idx = 5'd4;
    #1;
    chk("wrap_call_target", 32'(target), 32'h040);
    tick(); clr();
    ret = 1;
    #1;
    chk("wrap_ret_target", 32'(target), 32'h000);
    tick(); clr();

    // ret outranks call and jump
    prog_ctr = 12'h07F; call = 1; lut_idx = 5'd2;
    #1;
    chk("prio_call_target", 32'(target), 32'h020);
    tick(); clr();
    prog_ctr = 12'h090; ret = 1; call = 1; jump = 1; lut_idx = 5'd6;
    #1;
    chk("prio_ret_target", 32'(target), 32'h080);
    tick(); clr();
    chk("prio_ret_depth", 32'(depth), 0);

    // Overflow: fifth call faults
    for (int i = 0; i < 4; i++) begin
      prog_ctr = 12'(12'h100 + i); call = 1; lut_idx = 5'd5;
      #1;
      chk("fill_target", 32'(target), 32'h050);
      tick();
      chk("fill_depth", 32'(depth), 32'(i + 1));
    end
    prog_ctr = 12'h104;
    #1;
    chk("ovf_en", 32'(absjump_en), 1);
    chk("ovf_target", 32'(target), 32'h104);
    tick(); clr();
    chk("ovf_fault", 32'(fault), 1);
    chk("ovf_depth", 32'(depth), 4);
    chk("ovf_done", 32'(done), 0);
    prog_ctr = 12'h200; jump = 1; ret = 1; lut_idx = 5'd3;
    #1;
    chk("fault_hold_en", 32'(absjump_en), 1);
    chk("fault_hold_target", 32'(target), 32'h200);
    tick(); clr();
    chk("fault_hold_depth", 32'(depth), 4);
    chk("fault_sticky", 32'(fault), 1);
    do_reset();
    chk("fault_rst_fault", 32'(fault), 0);
    chk("fault_rst_depth", 32'(depth), 0);

    // Underflow: ret at depth 0 faults
    prog_ctr = 12'h030; ret = 1;
    #1;
    chk("unf_en", 32'(absjump_en), 1);
    chk("unf_target", 32'(target), 32'h030);
    tick(); clr();
    chk("unf_fault", 32'(fault), 1);
    chk("unf_depth", 32'(depth), 0);
    do_reset();

    // Halt outranks call; stack untouched while halted
    prog_ctr = 12'h020; call = 1; lut_idx = 5'd1;
    tick(); clr();
    chk("halt_pre_depth", 32'(depth), 1);
    prog_ctr = 12'h040; halt_req = 1; call = 1; lut_idx = 5'd1;
    #1;
    chk("halt_target", 32'(target), 32'h040);
    chk("halt_en", 32'(absjump_en), 1);
    tick(); clr();
    chk("halt_done", 32'(done), 1);
    chk("halt_depth", 32'(depth), 1);
    chk("halt_fault", 32'(fault), 0);
    prog_ctr = 12'h041; ret = 1;
    #1;
    chk("halted_target", 32'(target), 32'h041);
    tick(); clr();
    chk("halted_depth", 32'(depth), 1);
    do_reset();
    chk("halt_rst_done", 32'(done), 0);
    chk("halt_rst_depth", 32'(depth), 0);

`ifdef JUMP_LUT_WRITE_EN
    // Write and read same index in one cycle: old value first, new value next
    prog_ctr = 12'h010; jump = 1; lut_idx = 5'd3;
    lut_we = 1; lut_waddr = 5'd3; lut_wdata = 12'h123;
    #1;
    chk("lutw_old", 32'(target), 32'h030);
    tick();
    lut_we = 0;
    #1;
    chk("lutw_new", 32'(target), 32'h123);
    clr();
    do_reset();
    chk("lutw_rst_default", 32'(target), 32'h030);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
